// File: rtl/sram22_req_adapter.sv
// sram22_req_adapter
//   Client-side front end for a single-port sram22 macro. It turns a
//   valid/ready request stream into per-cycle macro pins. Read data comes
//   back through a 3-entry response FIFO on a valid/ready stream.
//   Optionally, after reset it zero-fills the whole array before accepting
//   any traffic.
//
// Ports
//   clk, rst                 clock shared with the macro; sync active-high reset
//   req_valid/req_ready      request handshake
//   req_we/wmask/addr/din    request fields (wmask ignored for reads)
//   rsp_valid/rsp_ready      read-response handshake (writes produce none)
//   rsp_dout                 read data at the FIFO head
//   sram_we/wmask/addr/din   macro input pins
//   sram_dout                macro read data (registered inside the macro)
//   init_done                high once the array is usable
module sram22_req_adapter #(
    parameter int DATA_WIDTH     = 4,
    parameter int ADDR_WIDTH     = 6,
    parameter int WMASK_WIDTH    = 2,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_din,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_dout,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout,
    output logic                   init_done
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic                    rd_pending;
    logic [DATA_WIDTH-1:0]   fifo_mem [0:2];
    logic [1:0]              wr_ptr, rd_ptr, fifo_count;
    logic [2:0]              credits_used;
    logic                    rd_credit_ok, accept, rd_accept, push, pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Every read in flight holds a FIFO slot, so the FIFO can never overflow.
    // This uses only registered state, so there is no path from rsp_ready.
    assign credits_used = {1'b0, fifo_count} + {2'b00, rd_pending};
    assign rd_credit_ok = (credits_used < 3'd3);

    assign accept    = (state == RUN) && req_valid && (req_we || rd_credit_ok);
    assign rd_accept = accept && !req_we;

    // The macro registers its read data, so it is valid one edge after the read.
    assign push      = rd_pending;
    assign rsp_valid = (fifo_count != 2'd0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_dout  = fifo_mem[rd_ptr];

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        init_done  = 1'b0;
        sram_we    = 1'b0;
        sram_wmask = '0;
        sram_addr  = '0;
        sram_din   = '0;
        if (state == CLEAR) begin
            sram_we    = 1'b1;
            sram_wmask = '1;
            sram_addr  = clr_addr;
            if (clr_addr == '1)
                state_nxt = RUN;
        end else begin
            init_done = 1'b1;
            req_ready = req_we || rd_credit_ok;
            if (accept) begin
                sram_we    = req_we;
                sram_wmask = req_we ? req_wmask : '0;
                sram_addr  = req_addr;
                sram_din   = req_din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_addr   <= '0;
            rd_pending <= 1'b0;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 2'd0;
        end else begin
            state <= state_nxt;
            // The counter wraps to 0 on the last sweep write.
            if (state == CLEAR)
                clr_addr <= clr_addr + 1'b1;
            // A new read on the same edge as a push keeps the flag set.
            rd_pending <= rd_accept;
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage is not reset. The head is a don't-care while rsp_valid is low.
    always_ff @(posedge clk) begin
        if (!rst && push)
            fifo_mem[wr_ptr] <= sram_dout;
    end

endmodule
